// File: rtl/clk_div_pkg.sv
// Shared constants, config record and channel state type for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned CNT_W      = 8;
  localparam int unsigned CH_IDX_W   = 4;
  localparam int unsigned DEF_PERIOD = 5;
  localparam int unsigned DEF_HIGH   = 2;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
  } cfg_t;

  typedef enum logic {StIdle, StRun} chan_st_e;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: shadow/active config, period counter, IDLE/RUN state, registered outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter cfg_t DefCfg = '{period: CNT_W'(DEF_PERIOD), high: CNT_W'(DEF_HIGH)}
) (
  input  logic clk_in,
  input  logic rst,
  input  logic en,
  input  logic wr_en,
  input  cfg_t wr_cfg,
  output logic clk_out,
  output logic tick,
  output logic pending
);

  chan_st_e         state_q, state_d;
  cfg_t             shadow_q, shadow_d;
  cfg_t             active_q, active_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  cfg_t             next_cfg;
  logic [CNT_W-1:0] cnt_inc;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en)  state_d = StRun;
      StRun:   if (!en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    cnt_d     = '0;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;
    cnt_inc   = cnt_q + CNT_W'(1);
    next_cfg  = pending_q ? shadow_q : active_q;
    unique case (state_q)
      StIdle: begin
        // While idle the shadow is applied every cycle, so a start always uses fresh config.
        active_d  = shadow_q;
        pending_d = 1'b0;
        if (en) begin
          tick_d    = 1'b1;
          clk_out_d = (shadow_q.high != '0);
        end
      end
      StRun: begin
        if (en) begin
          if (cnt_q == active_q.period) begin
            active_d  = next_cfg;
            pending_d = 1'b0;
            tick_d    = 1'b1;
            clk_out_d = (next_cfg.high != '0);
          end else begin
            cnt_d     = cnt_inc;
            clk_out_d = (cnt_inc < active_q.high);
          end
        end
      end
      default: ;
    endcase
    // A write coinciding with a wrap lands after the old shadow was consumed.
    if (wr_en) begin
      shadow_d  = wr_cfg;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      shadow_q  <= DefCfg;
      active_q  <= DefCfg;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign pending = pending_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: write decode, invalid-channel flag, channel array.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = clk_div_pkg::CNT_W,
  parameter int unsigned DEF_PERIOD = clk_div_pkg::DEF_PERIOD,
  parameter int unsigned DEF_HIGH   = clk_div_pkg::DEF_HIGH
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_high,
  output logic [NUM_CH-1:0]   clk_out,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   cfg_pending,
  output logic                cfg_err
);

  localparam cfg_t DefCfg = '{period: CNT_W'(DEF_PERIOD), high: CNT_W'(DEF_HIGH)};

  cfg_t wr_cfg;
  logic cfg_err_q, cfg_err_d;

  assign wr_cfg = '{period: cfg_period, high: cfg_high};

  always_comb begin
    cfg_err_d = cfg_we && (32'(cfg_ch) >= NUM_CH);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .DefCfg(DefCfg)
    ) u_chan (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (ch_en[i]),
      .wr_en   (cfg_we && (cfg_ch == CH_IDX_W'(i))),
      .wr_cfg  (wr_cfg),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pending (cfg_pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi with hand-computed output sequences.
module tb_clk_div_multi;

  logic       clk_in = 1'b0;
  logic       rst;
  logic [3:0] ch_en;
  logic       cfg_we;
  logic [3:0] cfg_ch;
  logic [7:0] cfg_period;
  logic [7:0] cfg_high;
  logic [3:0] clk_out;
  logic [3:0] tick;
  logic [3:0] cfg_pending;
  logic       cfg_err;

  int errors = 0;
  int checks = 0;

  int b_clk[8]  = '{0, 0, 0, 1, 1, 0, 0, 1};
  int b_tick[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  int b_pend[8] = '{1, 1, 1, 0, 0, 0, 0, 0};
  int c_clk[10]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  int c_tick[10] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
  int c_pend[10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};

  clk_div_multi u_dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .ch_en       (ch_en),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_high    (cfg_high),
    .clk_out     (clk_out),
    .tick        (tick),
    .cfg_pending (cfg_pending),
    .cfg_err     (cfg_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic write_cfg(input logic [3:0] ch, input logic [7:0] p, input logic [7:0] h);
    cfg_we     = 1'b1;
    cfg_ch     = ch;
    cfg_period = p;
    cfg_high   = h;
    step();
    cfg_we     = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    ch_en      = '0;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_period = '0;
    cfg_high   = '0;
    step();
    step();
    check_eq("rst_clk_out", 32'(clk_out), 32'h0);
    check_eq("rst_tick", 32'(tick), 32'h0);
    check_eq("rst_pending", 32'(cfg_pending), 32'h0);
    check_eq("rst_err", 32'(cfg_err), 32'h0);

    // Defaults on ch0: 110000 repeating
    rst   = 1'b0;
    ch_en = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      step();
      check_eq("a_clk0", 32'(clk_out[0]), (k % 6 < 2) ? 32'd1 : 32'd0);
      check_eq("a_tick0", 32'(tick[0]), (k % 6 == 0) ? 32'd1 : 32'd0);
      check_eq("a_pend", 32'(cfg_pending), 32'h0);
    end

    // ch1 reprogrammed mid-period: old 6-cycle period completes, then 1100
    ch_en = 4'b0011;
    step();
    check_eq("b_start_tick1", 32'(tick[1]), 32'd1);
    check_eq("b_start_clk1", 32'(clk_out[1]), 32'd1);
    step();
    step();
    write_cfg(4'd1, 8'd3, 8'd2);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) step();
      check_eq("b_clk1", 32'(clk_out[1]), 32'(b_clk[j]));
      check_eq("b_tick1", 32'(tick[1]), 32'(b_tick[j]));
      check_eq("b_pend1", 32'(cfg_pending[1]), 32'(b_pend[j]));
    end

    // ch2 period 4 high 0 while idle, then high 7 written on the wrap edge
    write_cfg(4'd2, 8'd4, 8'd0);
    check_eq("c_pend_set", 32'(cfg_pending[2]), 32'd1);
    step();
    check_eq("c_pend_idle_clr", 32'(cfg_pending[2]), 32'd0);
    ch_en = 4'b0111;
    for (int g = 0; g < 10; g++) begin
      step();
      check_eq("c_h0_clk2", 32'(clk_out[2]), 32'd0);
      check_eq("c_h0_tick2", 32'(tick[2]), (g % 5 == 0) ? 32'd1 : 32'd0);
    end
    write_cfg(4'd2, 8'd4, 8'd7);
    for (int j = 0; j < 10; j++) begin
      if (j > 0) step();
      check_eq("c_clk2", 32'(clk_out[2]), 32'(c_clk[j]));
      check_eq("c_tick2", 32'(tick[2]), 32'(c_tick[j]));
      check_eq("c_pend2", 32'(cfg_pending[2]), 32'(c_pend[j]));
    end

    // ch3 divide-by-1
    write_cfg(4'd3, 8'd0, 8'd1);
    step();
    check_eq("d_pend3", 32'(cfg_pending[3]), 32'd0);
    ch_en = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("d_tick3", 32'(tick[3]), 32'd1);
      check_eq("d_clk3", 32'(clk_out[3]), 32'd1);
    end

    // Invalid channel index
    cfg_we     = 1'b1;
    cfg_ch     = 4'd9;
    cfg_period = 8'd7;
    cfg_high   = 8'd7;
    step();
    cfg_we = 1'b0;
    check_eq("e_err_set", 32'(cfg_err), 32'd1);
    check_eq("e_pend", 32'(cfg_pending), 32'h0);
    step();
    check_eq("e_err_clr", 32'(cfg_err), 32'd0);
    check_eq("e_pend2", 32'(cfg_pending), 32'h0);
    check_eq("e_tick3", 32'(tick[3]), 32'd1);
    check_eq("e_clk3", 32'(clk_out[3]), 32'd1);

    // Reset mid-period with a pending write
    write_cfg(4'd1, 8'd9, 8'd3);
    check_eq("f_pend1", 32'(cfg_pending[1]), 32'd1);
    rst = 1'b1;
    step();
    check_eq("f_clk_out", 32'(clk_out), 32'h0);
    check_eq("f_tick", 32'(tick), 32'h0);
    check_eq("f_pend", 32'(cfg_pending), 32'h0);
    check_eq("f_err", 32'(cfg_err), 32'h0);
    ch_en = '0;
    step();
    rst = 1'b0;
    step();
    ch_en = 4'b0010;
    for (int k = 0; k < 12; k++) begin
      step();
      check_eq("f_clk1", 32'(clk_out[1]), (k % 6 < 2) ? 32'd1 : 32'd0);
      check_eq("f_tick1", 32'(tick[1]), (k % 6 == 0) ? 32'd1 : 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
